// File: rtl/envelope_meter_pkg.sv
// -----------------------------------------------------------------------------
// envelope_meter_pkg
// Shared constants for the stereo envelope meter: AXI-Lite register offsets,
// CTRL/STATUS bit positions, the clip threshold, the WINDOW reset value and
// the register-select decode used by the AXI-Lite block.
// -----------------------------------------------------------------------------
package envelope_meter_pkg;

  // Register byte offsets
  localparam logic [3:0] REG_CTRL_OFS   = 4'h0;
  localparam logic [3:0] REG_WINDOW_OFS = 4'h4;
  localparam logic [3:0] REG_PEAK_OFS   = 4'h8;
  localparam logic [3:0] REG_STATUS_OFS = 4'hC;

  // CTRL bits
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FRAME_BIT = 1;

  // STATUS bits (WCOUNT occupies [15:0])
  localparam int STATUS_NEW_BIT    = 16;
  localparam int STATUS_CLIP_L_BIT = 17;
  localparam int STATUS_CLIP_R_BIT = 18;

  localparam logic [15:0] CLIP_THRESH  = 16'h7FFF;
  localparam logic [15:0] WINDOW_RESET = 16'h0400;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_WINDOW,
    SEL_PEAK,
    SEL_STATUS,
    SEL_NONE
  } reg_sel_e;

  // Byte-lane bits [1:0] are ignored; registers are word aligned.
  function automatic reg_sel_e decode_reg(input logic [3:0] addr);
    reg_sel_e sel;
    case ({addr[3:2], 2'b00})
      REG_CTRL_OFS:   sel = SEL_CTRL;
      REG_WINDOW_OFS: sel = SEL_WINDOW;
      REG_PEAK_OFS:   sel = SEL_PEAK;
      REG_STATUS_OFS: sel = SEL_STATUS;
      default:        sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/envelope_meter_chan.sv
// -----------------------------------------------------------------------------
// envelope_meter_chan
// One metering channel: running maximum over the current window, the peak
// latched when a window closes, and a sticky clip flag.
//
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   sample_i        unsigned envelope sample for this channel
//   sample_en_i     sample is accepted and metering is enabled
//   close_i         this sample closes the window (only honoured with sample_en_i)
//   clear_run_i     discard the partial window (register write or meter disabled)
//   clip_clr_i      software clear of the clip flag
//   peak_o          last latched window peak
//   clip_o          sticky clip flag
// -----------------------------------------------------------------------------
module envelope_meter_chan
  import envelope_meter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             sample_en_i,
  input  logic             close_i,
  input  logic             clear_run_i,
  input  logic             clip_clr_i,
  output logic [WIDTH-1:0] peak_o,
  output logic             clip_o
);

  logic [WIDTH-1:0] run_q, run_d;
  logic [WIDTH-1:0] peak_q, peak_d;
  logic [WIDTH-1:0] run_max;
  logic             clip_q, clip_d;

  always_comb begin
    run_max = (sample_i > run_q) ? sample_i : run_q;
    run_d   = run_q;
    peak_d  = peak_q;
    clip_d  = clip_q;

    if (clear_run_i) begin
      run_d = '0;
    end else if (sample_en_i) begin
      if (close_i) begin
        // The closing sample itself takes part in the window peak.
        peak_d = run_max;
        run_d  = '0;
      end else begin
        run_d = run_max;
      end
    end

    // Clear first so that a clipping sample in the same cycle wins.
    if (clip_clr_i) begin
      clip_d = 1'b0;
    end
    if (sample_en_i && (sample_i >= WIDTH'(CLIP_THRESH))) begin
      clip_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      run_q  <= '0;
      peak_q <= '0;
      clip_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      peak_q <= peak_d;
      clip_q <= clip_d;
    end
  end

  assign peak_o = peak_q;
  assign clip_o = clip_q;

endmodule

// File: rtl/envelope_meter_axis.sv
// -----------------------------------------------------------------------------
// envelope_meter_axis
// Stereo envelope meter. The 32-bit envelope stream passes through a one-stage
// AXI4-Stream register slice untouched; per channel the maximum over a
// programmable sample window (or a TLAST-delimited frame) is latched and made
// visible over AXI4-Lite together with a window counter and sticky clip flags.
//
// Ports:
//   aclk, aresetn                 clock, synchronous active-low reset
//   s_axis_tdata/tlast/tvalid     envelope input, [15:0]=L, [31:16]=R
//   s_axis_tready                 input ready
//   m_axis_tdata/tlast/tvalid     registered pass-through output
//   m_axis_tready                 downstream ready
//   s_axi_*                       AXI4-Lite slave, registers:
//                                 0x0 CTRL, 0x4 WINDOW, 0x8 PEAK, 0xC STATUS
// -----------------------------------------------------------------------------
module envelope_meter_axis
  import envelope_meter_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int AUDIO_WIDTH        = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  // stream in
  input  logic [2*AUDIO_WIDTH-1:0]        s_axis_tdata,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  // stream out
  output logic [2*AUDIO_WIDTH-1:0]        m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  // AXI4-Lite write
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  // AXI4-Lite read
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
);

  // ---------------------------------------------------------------------------
  // Stream register slice
  // ---------------------------------------------------------------------------
  logic [2*AUDIO_WIDTH-1:0] tdata_q;
  logic                     tlast_q;
  logic                     tvalid_q;
  logic                     in_hs;
  logic                     out_hs;

  assign s_axis_tready = m_axis_tready || !tvalid_q;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign out_hs        = tvalid_q && m_axis_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (in_hs) begin
      tdata_q  <= s_axis_tdata;
      tlast_q  <= s_axis_tlast;
      tvalid_q <= 1'b1;
    end else if (out_hs) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;

  // ---------------------------------------------------------------------------
  // AXI4-Lite write channel
  // ---------------------------------------------------------------------------
  logic     awready_q;
  logic     bvalid_q;
  logic     wr_fire;
  reg_sel_e wr_sel;
  logic     ctrl_wr;
  logic     window_wr;
  logic     status_wr;

  // The write takes effect on the edge that completes the address/data
  // handshake; the master keeps addr/data stable until then.
  assign wr_fire   = awready_q && s_axi_awvalid && s_axi_wvalid;
  assign wr_sel    = decode_reg(s_axi_awaddr[3:0]);
  assign ctrl_wr   = wr_fire && (wr_sel == SEL_CTRL);
  assign window_wr = wr_fire && (wr_sel == SEL_WINDOW);
  assign status_wr = wr_fire && (wr_sel == SEL_STATUS);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      awready_q <= !awready_q && s_axi_awvalid && s_axi_wvalid;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
      end else if (s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;

  // ---------------------------------------------------------------------------
  // Control registers and window bookkeeping
  // ---------------------------------------------------------------------------
  logic        en_q;
  logic        frame_q;
  logic [15:0] window_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] wcount_q, wcount_d;
  logic        new_q, new_d;
  logic [15:0] win_last;
  logic        sample_en;
  logic        close_cond;
  logic        close_win;
  logic        clear_run;
  logic        rd_peak;

  // A window of 0 behaves like a window of 1.
  assign win_last   = (window_q == 16'd0) ? 16'd0 : (window_q - 16'd1);
  assign sample_en  = in_hs && en_q;
  assign close_cond = frame_q ? s_axis_tlast : (cnt_q == win_last);
  // A CTRL/WINDOW write restarts the window, so it suppresses a close.
  assign clear_run  = ctrl_wr || window_wr || !en_q;
  assign close_win  = sample_en && close_cond && !clear_run;

  always_comb begin
    cnt_d    = cnt_q;
    wcount_d = wcount_q;
    new_d    = new_q;

    if (clear_run) begin
      cnt_d = '0;
    end else if (sample_en) begin
      cnt_d = close_win ? 16'd0 : (cnt_q + 16'd1);
    end

    if (close_win) begin
      wcount_d = wcount_q + 16'd1;
    end

    // A latch in the same cycle as a PEAK read keeps NEW set.
    if (close_win) begin
      new_d = 1'b1;
    end else if (rd_peak) begin
      new_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      en_q     <= 1'b1;
      frame_q  <= 1'b0;
      window_q <= WINDOW_RESET;
      cnt_q    <= '0;
      wcount_q <= '0;
      new_q    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en_q    <= s_axi_wdata[CTRL_EN_BIT];
        frame_q <= s_axi_wdata[CTRL_FRAME_BIT];
      end
      if (window_wr) begin
        window_q <= s_axi_wdata[15:0];
      end
      cnt_q    <= cnt_d;
      wcount_q <= wcount_d;
      new_q    <= new_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel meters: index 0 = L (tdata low half), 1 = R
  // ---------------------------------------------------------------------------
  logic [AUDIO_WIDTH-1:0] peak_ch [2];
  logic                   clip_ch [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    envelope_meter_chan #(
      .WIDTH(AUDIO_WIDTH)
    ) u_chan (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .sample_i    (s_axis_tdata[gi*AUDIO_WIDTH +: AUDIO_WIDTH]),
      .sample_en_i (sample_en),
      .close_i     (close_win),
      .clear_run_i (clear_run),
      .clip_clr_i  (status_wr && s_axi_wdata[STATUS_CLIP_L_BIT + gi]),
      .peak_o      (peak_ch[gi]),
      .clip_o      (clip_ch[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // AXI4-Lite read channel
  // ---------------------------------------------------------------------------
  logic                          arready_q;
  logic                          rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
  logic                          rd_fire;
  reg_sel_e                      rd_sel;

  assign rd_fire = arready_q && s_axi_arvalid;
  assign rd_sel  = decode_reg(s_axi_araddr[3:0]);
  assign rd_peak = rd_fire && (rd_sel == SEL_PEAK);

  always_comb begin
    rd_word = '0;
    case (rd_sel)
      SEL_CTRL: begin
        rd_word[CTRL_EN_BIT]    = en_q;
        rd_word[CTRL_FRAME_BIT] = frame_q;
      end
      SEL_WINDOW: rd_word[15:0] = window_q;
      SEL_PEAK:   rd_word[2*AUDIO_WIDTH-1:0] = {peak_ch[1], peak_ch[0]};
      SEL_STATUS: begin
        rd_word[15:0]              = wcount_q;
        rd_word[STATUS_NEW_BIT]    = new_q;
        rd_word[STATUS_CLIP_L_BIT] = clip_ch[0];
        rd_word[STATUS_CLIP_R_BIT] = clip_ch[1];
      end
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      // One outstanding read: no new address until the data is taken.
      arready_q <= !arready_q && !rvalid_q && s_axi_arvalid;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;

  // Inputs that carry no information for this register map.
  logic unused_ok;
  assign unused_ok = &{1'b0, s_axi_wstrb, s_axi_wdata[C_S_AXI_DATA_WIDTH-1:19],
                       s_axi_wdata[16], s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_envelope_meter_axis.sv
module tb_envelope_meter_axis;

  logic        aclk;
  logic        aresetn;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [3:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  envelope_meter_axis dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  logic [32:0] exp_q[$];
  logic [31:0] rd_q[$];
  string       rd_name_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (window contents kept as sample lists)
  bit          mdl_en, mdl_frame, mdl_new, mdl_clip_l, mdl_clip_r;
  logic [15:0] mdl_window, mdl_peak_l, mdl_peak_r, mdl_wcount;
  logic [15:0] win_l[$], win_r[$];

  function automatic void model_reset();
    mdl_en = 1; mdl_frame = 0; mdl_window = 16'h0400;
    mdl_peak_l = 0; mdl_peak_r = 0; mdl_wcount = 0;
    mdl_new = 0; mdl_clip_l = 0; mdl_clip_r = 0;
    win_l.delete(); win_r.delete();
  endfunction

  function automatic void model_sample(input logic [15:0] l, input logic [15:0] r, input logic last);
    int eff;
    logic [15:0] ml, mr;
    if (!mdl_en) return;
    if (l >= 16'h7FFF) mdl_clip_l = 1;
    if (r >= 16'h7FFF) mdl_clip_r = 1;
    win_l.push_back(l);
    win_r.push_back(r);
    eff = (mdl_window == 0) ? 1 : int'(mdl_window);
    if (mdl_frame ? last : (win_l.size() >= eff)) begin
      ml = 0; mr = 0;
      foreach (win_l[i]) if (win_l[i] > ml) ml = win_l[i];
      foreach (win_r[i]) if (win_r[i] > mr) mr = win_r[i];
      mdl_peak_l = ml; mdl_peak_r = mr;
      mdl_wcount = mdl_wcount + 16'd1;
      mdl_new = 1;
      win_l.delete(); win_r.delete();
    end
  endfunction

  function automatic void model_write(input logic [3:0] addr, input logic [31:0] d);
    case (addr)
      4'h0: begin mdl_en = d[0]; mdl_frame = d[1]; win_l.delete(); win_r.delete(); end
      4'h4: begin mdl_window = d[15:0]; win_l.delete(); win_r.delete(); end
      4'hC: begin if (d[17]) mdl_clip_l = 0; if (d[18]) mdl_clip_r = 0; end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    logic [31:0] v;
    case (addr)
      4'h0: v = {30'd0, mdl_frame, mdl_en};
      4'h4: v = {16'd0, mdl_window};
      4'h8: begin v = {mdl_peak_r, mdl_peak_l}; mdl_new = 0; end
      4'hC: v = {13'd0, mdl_clip_r, mdl_clip_l, mdl_new, mdl_wcount};
      default: v = 0;
    endcase
    return v;
  endfunction

  // ---------------- monitor / scoreboard
  initial begin
    logic [32:0] e;
    @(posedge aclk);
    forever begin
      @(negedge aclk);
      chk("s_tready_rule", s_axis_tready, !(m_axis_tvalid && !m_axis_tready));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_extra: got 0x%0h expected no output", {m_axis_tlast, m_axis_tdata});
        end else begin
          e = exp_q.pop_front();
          chk("stream_data", {m_axis_tlast, m_axis_tdata}, e);
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdata_extra: got 0x%0h expected no read", s_axi_rdata);
        end else begin
          chk(rd_name_q.pop_front(), s_axi_rdata, rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers
  task automatic send(input logic [15:0] l, input logic [15:0] r, input logic last);
    int n = 0;
    bit ok = 0;
    s_axis_tdata = {r, l}; s_axis_tlast = last; s_axis_tvalid = 1;
    while (n < 200) begin
      @(negedge aclk);
      if (s_axis_tready) begin ok = 1; break; end
      n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no s_axis_tready expected accept");
    end else begin
      exp_q.push_back({last, r, l});
      model_sample(l, r, last);
    end
    @(posedge aclk); #1;
  endtask

  task automatic idle();
    s_axis_tvalid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(posedge aclk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge aclk); #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] d);
    s_axi_awaddr = addr; s_axi_wdata = d; s_axi_awvalid = 1; s_axi_wvalid = 1;
    @(posedge aclk); #1;
    chk("awready_pulse", {s_axi_awready, s_axi_wready}, 2'b11);
    @(posedge aclk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    chk("bvalid", {s_axi_bvalid, s_axi_bresp}, 3'b100);
    @(posedge aclk); #1;
    model_write(addr, d);
  endtask

  task automatic axi_read(input logic [3:0] addr, input string name);
    rd_q.push_back(model_read(addr));
    rd_name_q.push_back(name);
    s_axi_araddr = addr; s_axi_arvalid = 1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    s_axi_arvalid = 0;
    chk("rvalid_latency", s_axi_rvalid, 1);
    @(posedge aclk); #1;
  endtask

  // ---------------- stimulus
  initial begin
    int t0;
    logic [15:0] l, r;
    aresetn = 0;
    s_axis_tdata = 0; s_axis_tlast = 0; s_axis_tvalid = 0; m_axis_tready = 1;
    s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 4'hF; s_axi_wvalid = 0;
    s_axi_bready = 1; s_axi_araddr = 0; s_axi_arvalid = 0; s_axi_rready = 1;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_s_tready", s_axis_tready, 1);
    chk("rst_axi_hs", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    aresetn = 1;
    @(posedge aclk); #1;
    axi_read(4'h0, "rst_ctrl");
    axi_read(4'h4, "rst_window");
    axi_read(4'h8, "rst_peak");
    axi_read(4'hC, "rst_status");

    // Count mode, window of 4, back-to-back samples
    axi_write(4'h4, 32'd4);
    t0 = cyc;
    send(16'd10, 16'd7, 0);
    chk("latency_valid", m_axis_tvalid, 1);
    chk("latency_data", {m_axis_tlast, m_axis_tdata}, {1'b0, 16'd7, 16'd10});
    send(16'd300, 16'd7, 0);
    send(16'd20, 16'd7, 0);
    send(16'd5, 16'd9, 0);
    chk("throughput_cycles", cyc - t0, 4);
    idle(); drain();
    axi_read(4'hC, "win4_status");
    axi_read(4'h8, "win4_peak");
    axi_read(4'hC, "win4_status_new_clr");

    // Frame mode: tlast closes after 3 samples regardless of WINDOW=4
    axi_write(4'h0, 32'h3);
    send(16'd1, 16'd0, 0);
    send(16'd2, 16'd0, 0);
    send(16'h50, 16'd0, 1);
    idle(); drain();
    axi_read(4'h8, "frame_peak");
    axi_read(4'hC, "frame_status");

    // Clip set / clear / same-cycle set-over-clear
    axi_write(4'h0, 32'h1);
    send(16'h7FFF, 16'h10, 0);
    idle(); drain();
    axi_read(4'hC, "clip_set_status");
    axi_write(4'hC, 32'h20000);
    axi_read(4'hC, "clip_clr_status");
    s_axi_awaddr = 4'hC; s_axi_wdata = 32'h20000; s_axi_awvalid = 1; s_axi_wvalid = 1;
    @(posedge aclk); #1;
    s_axis_tdata = {16'h0, 16'h7FFF}; s_axis_tlast = 0; s_axis_tvalid = 1;
    @(negedge aclk);
    chk("same_cycle_accept", {s_axis_tready, s_axi_awready}, 2'b11);
    exp_q.push_back({1'b0, 16'h0, 16'h7FFF});
    @(posedge aclk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axis_tvalid = 0;
    @(posedge aclk); #1;
    model_write(4'hC, 32'h20000);
    model_sample(16'h7FFF, 16'h0, 0);
    drain();
    axi_read(4'hC, "clip_set_wins_status");

    // EN=0 freezes metering; then WINDOW=2 and WINDOW=0
    axi_write(4'h0, 32'h0);
    for (int i = 0; i < 10; i++) send(16'hFFFF - 16'(i), 16'(i * 1000), 1'(i == 4));
    idle(); drain();
    axi_read(4'h8, "en0_peak");
    axi_read(4'hC, "en0_status");
    axi_write(4'h4, 32'd2);
    axi_write(4'h0, 32'h1);
    send(16'd33, 16'd44, 0);
    idle(); drain();
    axi_read(4'hC, "win2_after1_status");
    send(16'd11, 16'd55, 0);
    idle(); drain();
    axi_read(4'hC, "win2_after2_status");
    axi_read(4'h8, "win2_peak");
    axi_write(4'h4, 32'd0);
    send(16'd123, 16'd456, 0);
    idle(); drain();
    axi_read(4'h8, "win0_peak");
    axi_read(4'hC, "win0_status");

    // Randomized blocks with random downstream backpressure
    for (int blk = 0; blk < 4; blk++) begin
      axi_write(4'h4, 32'($urandom_range(0, 6)));
      axi_write(4'h0, {30'd0, 1'(blk % 2), 1'b1});
      axi_write(4'hC, 32'h60000);
      rand_ready = 1;
      for (int i = 0; i < 250; i++) begin
        l = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(16'h7FF0, 16'hFFFF)) : 16'($urandom_range(0, 16'h7000));
        r = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(16'h7FF0, 16'hFFFF)) : 16'($urandom_range(0, 16'h7000));
        send(l, r, 1'($urandom_range(0, 5) == 0));
        if ($urandom_range(0, 3) == 0) begin
          idle();
          repeat ($urandom_range(1, 3)) @(posedge aclk);
          #1;
        end
      end
      idle(); drain();
      rand_ready = 0; m_axis_tready = 1;
      @(posedge aclk); #1;
      axi_read(4'hC, $sformatf("rand%0d_status", blk));
      axi_read(4'h8, $sformatf("rand%0d_peak", blk));
    end

    // Reset mid-window with an output word held
    axi_write(4'h4, 32'd8);
    axi_write(4'h0, 32'h1);
    send(16'd900, 16'd800, 0);
    send(16'd901, 16'd801, 0);
    idle(); drain();
    m_axis_tready = 0;
    send(16'd902, 16'd802, 0);
    idle();
    chk("pre_reset_held", m_axis_tvalid, 1);
    aresetn = 0;
    exp_q.delete();
    model_reset();
    @(posedge aclk); #1;
    chk("post_reset_tvalid", m_axis_tvalid, 0);
    m_axis_tready = 1;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1;
    repeat (3) @(posedge aclk);
    #1;
    axi_read(4'h8, "after_rst_peak");
    axi_read(4'hC, "after_rst_status");
    axi_read(4'h0, "after_rst_ctrl");
    axi_read(4'h4, "after_rst_window");

    repeat (3) @(posedge aclk);
    chk("stream_queue_empty", exp_q.size(), 0);
    chk("read_queue_empty", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
